// File: rtl/dmem_arbiter_pkg.sv
// Shared state encodings, owner constants and the tie-break rule for the
// data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic ARB_CPU = 1'b0;
    localparam logic ARB_DBG = 1'b1;
    localparam int   CNT_W   = 4;

    // On a tie the port that did not win the previous grant takes this one.
    function automatic logic arb_pick(
        input logic cpu_req,
        input logic dbg_req,
        input logic last_owner
    );
        logic win;
        if (cpu_req && dbg_req) begin
            win = ~last_owner;
        end else if (dbg_req) begin
            win = ARB_DBG;
        end else begin
            win = ARB_CPU;
        end
        return win;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data-memory port between the CPU mem stage and the
// debug/loader port; every access is IDLE (grant) -> ACC (MEM_LAT cycles) -> RESP.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_done_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [1:0]        arb_state_o
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    logic              w_cpu_req;
    logic              w_grant;
    logic              w_winner;
    logic              w_acc_last;

    // A CPU request with both strobes high is treated as a write.
    assign w_cpu_req  = cpu_read_i | cpu_write_i;
    assign w_grant    = (r_state == ARB_IDLE) && (w_cpu_req || dbg_req_i);
    assign w_winner   = arb_pick(w_cpu_req, dbg_req_i, r_last_owner);
    assign w_acc_last = (r_state == ARB_ACC) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant) begin
                    w_next_state = ARB_ACC;
                end
            end
            ARB_ACC: begin
                if (r_cnt == '0) begin
                    w_next_state = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_next_state = ARB_IDLE;
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // Command capture, latency counter and per-port read-data holding registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_owner      <= ARB_CPU;
            r_last_owner <= ARB_DBG;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                r_cnt        <= LAT_LAST;
                if (w_winner == ARB_DBG) begin
                    r_cmd_we    <= dbg_we_i;
                    r_cmd_addr  <= dbg_addr_i;
                    r_cmd_wdata <= dbg_wdata_i;
                end else begin
                    r_cmd_we    <= cpu_write_i;
                    r_cmd_addr  <= cpu_addr_i;
                    r_cmd_wdata <= cpu_wdata_i;
                end
            end else if ((r_state == ARB_ACC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_acc_last && !r_cmd_we) begin
                if (r_owner == ARB_DBG) begin
                    r_dbg_rdata <= mem_data_i;
                end else begin
                    r_cpu_rdata <= mem_data_i;
                end
            end
        end
    end

    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        cpu_done_o  = 1'b0;
        dbg_ack_o   = 1'b0;
        case (r_state)
            ARB_ACC: begin
                mem_read_o  = ~r_cmd_we;
                mem_write_o = r_cmd_we;
                mem_addr_o  = r_cmd_addr;
                mem_data_o  = r_cmd_we ? r_cmd_wdata : '0;
            end
            ARB_RESP: begin
                cpu_done_o = (r_owner == ARB_CPU);
                dbg_ack_o  = (r_owner == ARB_DBG);
            end
            default: begin
            end
        endcase
    end

    assign cpu_stall_o = w_cpu_req & ~cpu_done_o;
    assign cpu_rdata_o = r_cpu_rdata;
    assign dbg_rdata_o = r_dbg_rdata;
    assign arb_state_o = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (MEM_LAT 1, 3, 4) exercised one at a
// time against a transaction-schedule reference model.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int N  = 3;

    logic          clk;
    logic          rst_n     [N];
    logic          cpu_read  [N];
    logic          cpu_write [N];
    logic [AW-1:0] cpu_addr  [N];
    logic [DW-1:0] cpu_wdata [N];
    logic [DW-1:0] cpu_rdata [N];
    logic          cpu_done  [N];
    logic          cpu_stall [N];
    logic          dbg_req   [N];
    logic          dbg_we    [N];
    logic [AW-1:0] dbg_addr  [N];
    logic [DW-1:0] dbg_wdata [N];
    logic [DW-1:0] dbg_rdata [N];
    logic          dbg_ack   [N];
    logic          mem_read  [N];
    logic          mem_write [N];
    logic [AW-1:0] mem_addr  [N];
    logic [DW-1:0] mem_wdata [N];
    wire  [DW-1:0] mem_rdata [N];
    logic [1:0]    arb_state [N];

    logic [DW-1:0] dev_mem [N][256];
    bit            dev_wr  [N][256];

    function automatic logic [DW-1:0] seed_word(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
            .clk         (clk),
            .rst         (rst_n[g]),
            .cpu_read_i  (cpu_read[g]),
            .cpu_write_i (cpu_write[g]),
            .cpu_addr_i  (cpu_addr[g]),
            .cpu_wdata_i (cpu_wdata[g]),
            .cpu_rdata_o (cpu_rdata[g]),
            .cpu_done_o  (cpu_done[g]),
            .cpu_stall_o (cpu_stall[g]),
            .dbg_req_i   (dbg_req[g]),
            .dbg_we_i    (dbg_we[g]),
            .dbg_addr_i  (dbg_addr[g]),
            .dbg_wdata_i (dbg_wdata[g]),
            .dbg_rdata_o (dbg_rdata[g]),
            .dbg_ack_o   (dbg_ack[g]),
            .mem_read_o  (mem_read[g]),
            .mem_write_o (mem_write[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_data_o  (mem_wdata[g]),
            .mem_data_i  (mem_rdata[g]),
            .arb_state_o (arb_state[g])
        );
        assign mem_rdata[g] = (mem_read[g] !== 1'b1) ? 32'h0BAD_F00D :
                              dev_wr[g][mem_addr[g]] ? dev_mem[g][mem_addr[g]] :
                              seed_word(mem_addr[g]);
    end

    // Clock / memory device
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (mem_write[i] === 1'b1) begin
                dev_mem[i][mem_addr[i]] <= mem_wdata[i];
                dev_wr[i][mem_addr[i]]  <= 1'b1;
            end
        end
    end

    // Reference model: schedule of the single in-flight access
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            k_act = 0;
    int            lat = 1;
    bit            m_active = 1'b0;
    int            m_g = 0;
    bit            m_owner = 1'b0;
    bit            m_we = 1'b0;
    bit            m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] ref_mem [256];
    bit            ref_wr [256];
    logic [0:0]    exp_q [$];
    bit            e_acc, e_cpu_done, e_dbg_ack;
    int            n_cpu_pulse, n_dbg_pulse;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (inst %0d cyc %0d)", tag, obs, exp, k_act, cyc);
        end
    endtask

    task automatic step();
        bit         c_req;
        bit         d_req;
        int         off;
        logic [0:0] q_owner;
        @(posedge clk);
        cyc++;
        if (rst_n[k_act] == 1'b0) begin
            m_active  = 1'b0;
            m_last    = 1'b1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            exp_q.delete();
        end else begin
            if (m_active && (cyc >= m_g + lat + 2)) m_active = 1'b0;
            if (!m_active) begin
                c_req = cpu_read[k_act] | cpu_write[k_act];
                d_req = dbg_req[k_act];
                if (c_req || d_req) begin
                    m_owner  = (c_req && d_req) ? !m_last : d_req;
                    m_last   = m_owner;
                    m_active = 1'b1;
                    m_g      = cyc;
                    if (m_owner) begin
                        m_we = dbg_we[k_act]; m_addr = dbg_addr[k_act]; m_wdata = dbg_wdata[k_act];
                    end else begin
                        m_we = cpu_write[k_act]; m_addr = cpu_addr[k_act]; m_wdata = cpu_wdata[k_act];
                    end
                    exp_q.push_back(m_owner);
                end
            end
            if (m_active && (cyc == m_g + lat)) begin
                if (m_we) begin
                    ref_mem[m_addr] = m_wdata;
                    ref_wr[m_addr]  = 1'b1;
                end else begin
                    exp_rd[m_owner] = ref_wr[m_addr] ? ref_mem[m_addr] : seed_word(m_addr);
                end
            end
        end
        #1;
        off        = cyc - m_g;
        e_acc      = m_active && (off < lat);
        e_cpu_done = m_active && (off == lat) && !m_owner;
        e_dbg_ack  = m_active && (off == lat) && m_owner;
        check_val("mem_read",  mem_read[k_act],  e_acc && !m_we);
        check_val("mem_write", mem_write[k_act], e_acc && m_we);
        check_val("mem_addr",  mem_addr[k_act],  e_acc ? m_addr : '0);
        check_val("mem_data",  mem_wdata[k_act], (e_acc && m_we) ? m_wdata : '0);
        check_val("cpu_done",  cpu_done[k_act],  e_cpu_done);
        check_val("dbg_ack",   dbg_ack[k_act],   e_dbg_ack);
        check_val("cpu_rdata", cpu_rdata[k_act], exp_rd[0]);
        check_val("dbg_rdata", dbg_rdata[k_act], exp_rd[1]);
        check_val("cpu_stall", cpu_stall[k_act], (cpu_read[k_act] | cpu_write[k_act]) & !e_cpu_done);
        if ((cpu_done[k_act] === 1'b1) || (dbg_ack[k_act] === 1'b1)) begin
            if (cpu_done[k_act] === 1'b1) n_cpu_pulse++;
            if (dbg_ack[k_act] === 1'b1) n_dbg_pulse++;
            check_val("done_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                q_owner = exp_q.pop_front();
                check_val("done_owner", dbg_ack[k_act], q_owner);
            end
        end
    endtask

    // Driver tasks
    task automatic clear_cpu();
        cpu_read[k_act]  = 1'b0;
        cpu_write[k_act] = 1'b0;
    endtask

    task automatic clear_dbg();
        dbg_req[k_act] = 1'b0;
        dbg_we[k_act]  = 1'b0;
    endtask

    task automatic new_cpu();
        int t;
        t = $urandom_range(0, 2);
        cpu_read[k_act]  = (t != 1);
        cpu_write[k_act] = (t != 0);
        cpu_addr[k_act]  = 8'($urandom_range(0, 15));
        cpu_wdata[k_act] = $urandom;
    endtask

    task automatic new_dbg();
        dbg_req[k_act]   = 1'b1;
        dbg_we[k_act]    = 1'($urandom_range(0, 1));
        dbg_addr[k_act]  = 8'($urandom_range(0, 15));
        dbg_wdata[k_act] = $urandom;
    endtask

    task automatic drive_random();
        if (cpu_read[k_act] | cpu_write[k_act]) begin
            if (e_cpu_done) begin
                if ($urandom_range(0, 1) == 1) new_cpu(); else clear_cpu();
            end else if (e_acc && !m_owner) begin
                cpu_addr[k_act]  = 8'($urandom);
                cpu_wdata[k_act] = $urandom;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            new_cpu();
        end
        if (dbg_req[k_act]) begin
            if (e_dbg_ack) begin
                if ($urandom_range(0, 1) == 1) new_dbg(); else clear_dbg();
            end else if (e_acc && m_owner) begin
                dbg_addr[k_act]  = 8'($urandom);
                dbg_wdata[k_act] = $urandom;
                dbg_we[k_act]    = ~dbg_we[k_act];
            end
        end else if ($urandom_range(0, 3) == 0) begin
            new_dbg();
        end
    endtask

    // One complete access from an otherwise idle arbiter; bounded by a cycle budget.
    task automatic access(input bit port, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n_acc;
        bit seen;
        n_acc = 0;
        seen  = 1'b0;
        if (port == 1'b0) begin
            cpu_read[k_act] = rd; cpu_write[k_act] = wr; cpu_addr[k_act] = a; cpu_wdata[k_act] = d;
        end else begin
            dbg_req[k_act] = 1'b1; dbg_we[k_act] = wr; dbg_addr[k_act] = a; dbg_wdata[k_act] = d;
        end
        for (int i = 0; (i < lat + 4) && !seen; i++) begin
            step();
            if ((mem_read[k_act] === 1'b1) || (mem_write[k_act] === 1'b1)) n_acc++;
            if (((port == 1'b0) ? cpu_done[k_act] : dbg_ack[k_act]) === 1'b1) seen = 1'b1;
        end
        if (port == 1'b0) clear_cpu(); else clear_dbg();
        check_val("acc_len", n_acc, lat);
        check_val("acc_done_seen", seen, 1'b1);
        step();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0; cpu_read[k] = 1'b0; cpu_write[k] = 1'b0;
            cpu_addr[k] = '0; cpu_wdata[k] = '0; dbg_req[k] = 1'b0;
            dbg_we[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
        end
        repeat (2) @(posedge clk);

        for (int k = 0; k < N; k++) begin
            k_act = k;
            lat   = lat_of(k);
            for (int a = 0; a < 256; a++) begin
                ref_wr[a]  = 1'b0;
                ref_mem[a] = '0;
            end

            // Reset with both requests high, then continuous contention on reads
            cpu_read[k] = 1'b1; cpu_addr[k] = 8'h10;
            dbg_req[k] = 1'b1; dbg_we[k] = 1'b0; dbg_addr[k] = 8'h20;
            rst_n[k] = 1'b0;
            step();
            step();
            check_val("rst_state", arb_state[k], 2'd0);
            rst_n[k] = 1'b1;
            n_cpu_pulse = 0;
            n_dbg_pulse = 0;
            for (int i = 0; i < 4 * (lat + 2) + 1; i++) begin
                step();
                if (i == 0) check_val("first_grant_addr", mem_addr[k], 8'h10);
            end
            check_val("tie_cpu_cnt", n_cpu_pulse, 2);
            check_val("tie_dbg_cnt", n_dbg_pulse, 2);
            clear_cpu();
            clear_dbg();
            repeat (lat + 3) step();

            // Directed accesses
            access(1'b1, 1'b0, 1'b1, 8'h20, 32'h1234_5678);
            check_val("dbg_rdata_hold", dbg_rdata[k], seed_word(8'h20));
            access(1'b1, 1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF);
            access(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
            check_val("cpu_rd_deadbeef", cpu_rdata[k], 32'hDEAD_BEEF);
            access(1'b0, 1'b1, 1'b1, 8'h05, 32'hA5A5_0005);
            access(1'b1, 1'b1, 1'b0, 8'h05, 32'h0);
            check_val("dbg_rd_both_wr", dbg_rdata[k], 32'hA5A5_0005);

            // Reset during the second ACC cycle aborts the access
            if (lat >= 2) begin
                cpu_read[k] = 1'b1; cpu_write[k] = 1'b0; cpu_addr[k] = 8'h05;
                step();
                step();
                rst_n[k]    = 1'b0;
                cpu_read[k] = 1'b0;
                step();
                check_val("rst_acc_strobe", mem_read[k], 1'b0);
                rst_n[k] = 1'b1;
                n_cpu_pulse = 0;
                repeat (lat + 3) step();
                check_val("rst_acc_no_done", n_cpu_pulse, 0);
                access(1'b0, 1'b1, 1'b0, 8'h05, 32'h0);
                check_val("post_rst_read", cpu_rdata[k], 32'hA5A5_0005);
            end

            // Randomized traffic
            repeat (300) begin
                step();
                drive_random();
            end
            clear_cpu();
            clear_dbg();
            repeat (lat + 3) step();
            check_val("q_drain", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
